// File: rtl/imem_boot_controller.sv
// UART boot loader for the instruction memory: parses a framed, XOR-checksummed
// image, writes each word, zero-fills the remaining addresses and then releases the CPU.
module imem_boot_controller #(
    parameter int          ADDR_W      = 5,
    parameter int          DEPTH       = 32,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int          TIMEOUT_CYC = 1000000
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              load_start,
    input  logic              boot_bypass,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              load_done,
    output logic              cpu_hold,
    output logic [1:0]        error_code
);

    localparam int              CNT_W   = ADDR_W + 1;
    localparam int              TO_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [7:0]      DEPTH_B = 8'(DEPTH);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_WAIT_SYNC,
        S_GET_COUNT,
        S_GET_HI,
        S_GET_LO,
        S_GET_CSUM,
        S_FILL,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q;
    logic [7:0]        csum_q;
    logic [7:0]        hi_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  idx_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [15:0]       wr_data_q;
    logic              load_done_q;
    logic [1:0]        err_q;

    // Loader FSM with all outputs registered; load_start wins over any byte except during FILL.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= S_WAIT_SYNC;
            csum_q      <= 8'h00;
            hi_q        <= 8'h00;
            count_q     <= '0;
            idx_q       <= '0;
            to_cnt_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 16'h0000;
            load_done_q <= 1'b0;
            err_q       <= 2'd0;
        end else begin
            wr_en_q <= 1'b0;
            if (load_start && (state_q != S_FILL)) begin
                state_q     <= S_WAIT_SYNC;
                load_done_q <= 1'b0;
                err_q       <= 2'd0;
                csum_q      <= 8'h00;
                idx_q       <= '0;
                to_cnt_q    <= '0;
            end else begin
                case (state_q)
                    S_WAIT_SYNC: begin
                        to_cnt_q <= '0;
                        if (boot_bypass) begin
                            state_q <= S_DONE;
                        end else if (rx_valid && (rx_data == SYNC_BYTE)) begin
                            state_q <= S_GET_COUNT;
                        end else begin
                            state_q <= S_WAIT_SYNC;
                        end
                    end
                    S_GET_COUNT, S_GET_HI, S_GET_LO, S_GET_CSUM: begin
                        if (rx_valid) begin
                            to_cnt_q <= '0;
                            case (state_q)
                                S_GET_COUNT: begin
                                    if ((rx_data == 8'd0) || (rx_data > DEPTH_B)) begin
                                        state_q <= S_ERROR;
                                        err_q   <= 2'd3;
                                    end else begin
                                        count_q   <= CNT_W'(rx_data);
                                        csum_q    <= rx_data;
                                        idx_q     <= '0;
                                        wr_addr_q <= '0;
                                        state_q   <= S_GET_HI;
                                    end
                                end
                                S_GET_HI: begin
                                    hi_q    <= rx_data;
                                    csum_q  <= csum_q ^ rx_data;
                                    state_q <= S_GET_LO;
                                end
                                S_GET_LO: begin
                                    wr_en_q   <= 1'b1;
                                    wr_addr_q <= idx_q[ADDR_W-1:0];
                                    wr_data_q <= {hi_q, rx_data};
                                    csum_q    <= csum_q ^ rx_data;
                                    idx_q     <= idx_q + CNT_W'(1);
                                    if ((idx_q + CNT_W'(1)) == count_q) begin
                                        state_q <= S_GET_CSUM;
                                    end else begin
                                        state_q <= S_GET_HI;
                                    end
                                end
                                S_GET_CSUM: begin
                                    if (rx_data != csum_q) begin
                                        state_q <= S_ERROR;
                                        err_q   <= 2'd1;
                                    end else if (count_q < DEPTH_C) begin
                                        state_q <= S_FILL;
                                    end else begin
                                        state_q <= S_DONE;
                                    end
                                end
                                default: state_q <= S_ERROR;
                            endcase
                        end else if (to_cnt_q == TO_LAST) begin
                            state_q <= S_ERROR;
                            err_q   <= 2'd2;
                        end else begin
                            to_cnt_q <= to_cnt_q + TO_W'(1);
                        end
                    end
                    // idx_q already equals N on entry, so fill continues right after the image.
                    S_FILL: begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= idx_q[ADDR_W-1:0];
                        wr_data_q <= 16'h0000;
                        idx_q     <= idx_q + CNT_W'(1);
                        if (idx_q == (DEPTH_C - CNT_W'(1))) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_FILL;
                        end
                    end
                    S_DONE: begin
                        load_done_q <= 1'b1;
                    end
                    S_ERROR: begin
                        load_done_q <= 1'b0;
                    end
                    default: begin
                        state_q <= S_WAIT_SYNC;
                    end
                endcase
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign load_done  = load_done_q;
    assign cpu_hold   = ~load_done_q;
    assign error_code = err_q;

endmodule

// File: tb/tb_imem_boot_controller.sv
// Self-checking bench for imem_boot_controller: directed scenarios plus random frames
// compared against an image-level model of the expected memory writes and status.
module tb_imem_boot_controller;

    localparam int         ADDR_W      = 5;
    localparam int         DEPTH       = 32;
    localparam int         TIMEOUT_CYC = 40;
    localparam logic [7:0] SYNC        = 8'hA5;

    logic              CLK = 1'b0;
    logic              reset = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              load_start = 1'b0;
    logic              boot_bypass = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              load_done;
    logic              cpu_hold;
    logic [1:0]        error_code;

    imem_boot_controller #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .CLK(CLK), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .load_start(load_start), .boot_bypass(boot_bypass), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .load_done(load_done),
        .cpu_hold(cpu_hold), .error_code(error_code)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_wr_cyc = -1;
    int          ld_rise_cyc = -1;
    logic        ld_prev = 1'b0;
    logic [31:0] wq [$];
    logic [15:0] words [DEPTH];

    // Write monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (wr_en) begin
            wq.push_back({11'd0, wr_addr, wr_data});
            last_wr_cyc <= cyc + 1;
        end
        if (load_done && !ld_prev) ld_rise_cyc <= cyc + 1;
        ld_prev <= load_done;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge CLK);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_load();
        load_start = 1'b1;
        @(negedge CLK);
        load_start = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit good, input int max_gap);
        logic [7:0] cs;
        cs = 8'(n);
        send_byte(SYNC);
        tick($urandom_range(0, max_gap));
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            tick($urandom_range(0, max_gap));
            send_byte(words[i][15:8]);
            tick($urandom_range(0, max_gap));
            send_byte(words[i][7:0]);
            cs = cs ^ words[i][15:8] ^ words[i][7:0];
        end
        tick($urandom_range(0, max_gap));
        if (good) send_byte(cs);
        else      send_byte(cs ^ 8'($urandom_range(1, 255)));
    endtask

    task automatic wait_end();
        int k;
        k = 0;
        while (!load_done && (error_code == 2'd0) && (k < 100)) begin
            @(negedge CLK);
            k++;
        end
        check_val("end_bound", 32'(k < 100), 32'd1);
    endtask

    // Model: good image -> words at 0..n-1 then zeros to DEPTH-1; bad checksum -> only the n words.
    task automatic check_load(input int n, input bit good, input int base);
        int exp_cnt;
        exp_cnt = good ? DEPTH : n;
        check_val("wr_count", 32'(wq.size() - base), 32'(exp_cnt));
        for (int i = 0; i < exp_cnt; i++) begin
            if (base + i < wq.size())
                check_val("wr", wq[base + i], {11'd0, 5'(i), (i < n) ? words[i] : 16'h0000});
        end
        check_val("err", 32'(error_code), good ? 32'd0 : 32'd1);
        check_val("load_done", 32'(load_done), 32'(good));
        check_val("cpu_hold", 32'(cpu_hold), 32'(!good));
        if (good && (n < DEPTH))
            check_val("ld_latency", 32'(ld_rise_cyc - last_wr_cyc), 32'd1);
    endtask

    logic [7:0] t1 [7] = '{8'hA5, 8'h02, 8'h10, 8'h4E, 8'h30, 8'h44, 8'h28};

    initial begin
        int         base;
        int         n;
        bit         good;
        logic [7:0] b;

        tick(2);
        check_val("rst_wr_en", 32'(wr_en), 32'd0);
        check_val("rst_wr_addr", 32'(wr_addr), 32'd0);
        check_val("rst_wr_data", 32'(wr_data), 32'd0);
        check_val("rst_load_done", 32'(load_done), 32'd0);
        check_val("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check_val("rst_err", 32'(error_code), 32'd0);
        reset = 1'b0;
        tick(1);

        // Reference frame from the test plan.
        words[0] = 16'h104E;
        words[1] = 16'h3044;
        base = wq.size();
        for (int i = 0; i < 7; i++) send_byte(t1[i]);
        wait_end();
        tick(3);
        check_load(2, 1'b1, base);

        // Bad checksum, then recovery.
        pulse_load();
        base = wq.size();
        for (int i = 0; i < 6; i++) send_byte(t1[i]);
        send_byte(8'h29);
        wait_end();
        tick(3);
        check_load(2, 1'b0, base);
        pulse_load();
        check_val("err_cleared", 32'(error_code), 32'd0);
        base = wq.size();
        send_frame(2, 1'b1, 0);
        wait_end();
        tick(3);
        check_load(2, 1'b1, base);

        // Inter-byte timeout.
        pulse_load();
        base = wq.size();
        send_byte(SYNC); send_byte(8'h03); send_byte(8'h12); send_byte(8'h34);
        tick(TIMEOUT_CYC - 5);
        check_val("to_early", 32'(error_code), 32'd0);
        tick(10);
        check_val("to_err", 32'(error_code), 32'd2);
        check_val("to_wr_count", 32'(wq.size() - base), 32'd1);
        if (wq.size() > base) check_val("to_wr", wq[base], 32'h0000_1234);
        check_val("to_cpu_hold", 32'(cpu_hold), 32'd1);

        // Bad word counts.
        pulse_load();
        base = wq.size();
        send_byte(SYNC); send_byte(8'h00);
        tick(2);
        check_val("cnt0_err", 32'(error_code), 32'd3);
        pulse_load();
        send_byte(SYNC); send_byte(8'h21);
        tick(2);
        check_val("cnt33_err", 32'(error_code), 32'd3);
        check_val("cnt_wr_count", 32'(wq.size() - base), 32'd0);

        // Bypass after reset.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        boot_bypass = 1'b1;
        tick(2);
        check_val("byp_load_done", 32'(load_done), 32'd1);
        base = wq.size();
        for (int i = 0; i < 7; i++) send_byte(t1[i]);
        tick(3);
        check_val("byp_wr_count", 32'(wq.size() - base), 32'd0);
        check_val("byp_still_done", 32'(load_done), 32'd1);
        boot_bypass = 1'b0;
        pulse_load();
        check_val("byp_reload", 32'(load_done), 32'd0);

        // Reset between hi and lo of word 1.
        base = wq.size();
        for (int i = 0; i < 5; i++) send_byte(t1[i]);
        reset = 1'b1;
        #1;
        check_val("mid_wr_data", 32'(wr_data), 32'd0);
        check_val("mid_wr_en", 32'(wr_en), 32'd0);
        check_val("mid_cpu_hold", 32'(cpu_hold), 32'd1);
        check_val("mid_err", 32'(error_code), 32'd0);
        @(negedge CLK);
        reset = 1'b0;
        send_byte(8'h44);
        tick(3);
        check_val("mid_wr_count", 32'(wq.size() - base), 32'd1);
        for (int i = 0; i < DEPTH; i++) words[i] = 16'($urandom);
        base = wq.size();
        send_frame(5, 1'b1, 1);
        wait_end();
        tick(3);
        check_load(5, 1'b1, base);

        // load_start together with a sync byte: the byte must be dropped.
        load_start = 1'b1;
        rx_valid   = 1'b1;
        rx_data    = SYNC;
        @(negedge CLK);
        load_start = 1'b0;
        rx_valid   = 1'b0;
        check_val("ls_load_done", 32'(load_done), 32'd0);
        base = wq.size();
        send_byte(8'h03);
        words[0] = 16'h104E;
        words[1] = 16'h3044;
        send_frame(2, 1'b1, 0);
        wait_end();
        tick(3);
        check_load(2, 1'b1, base);

        // Random frames with junk before sync and random inter-byte gaps.
        for (int it = 0; it < 10; it++) begin
            pulse_load();
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                b = 8'($urandom_range(0, 255));
                if (b == SYNC) b = 8'h00;
                send_byte(b);
            end
            n    = (it == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
            good = (it == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            for (int i = 0; i < DEPTH; i++) words[i] = 16'($urandom);
            base = wq.size();
            send_frame(n, good, 3);
            wait_end();
            tick(3);
            check_load(n, good, base);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_boot_controller.md
Name: imem_boot_controller

Overview:
- Sequences the UART boot load of the 16-bit instruction memory; sits between the UART receiver byte stream and the instruction memory write port.
- Parses a framed, checksummed program image and issues one-cycle word writes.
- Zero-fills unused addresses, then releases the CPU.
- Holds the CPU (cpu_hold) until a valid image is loaded; supports reload on request and a bypass for preloaded debug images.

Parameters:
- ADDR_W, 5, instruction memory address width.
- DEPTH, 32, number of instruction words (2**ADDR_W).
- SYNC_BYTE, 8'hA5, frame start byte.
- TIMEOUT_CYC, 1000000, maximum CLK cycles between bytes inside a frame.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_valid  input  1  one-cycle strobe, a received UART byte is on rx_data.
- rx_data  input  8  received byte, valid only when rx_valid=1.
- load_start  input  1  one-cycle request to (re)load an image.
- boot_bypass  input  1  skip loading; treat memory as already valid.
- wr_en  output  1  one-cycle instruction memory write strobe.
- wr_addr  output  ADDR_W  write address.
- wr_data  output  16  write word, {hi byte, lo byte}.
- load_done  output  1  image valid; CPU may run.
- cpu_hold  output  1  CPU held; equals ~load_done.
- error_code  output  2  0 none, 1 checksum, 2 timeout, 3 bad count; sticky until the next load_start.

Behaviour:
- Reset (async, immediate):
  - Outputs: wr_en=0, wr_addr=0, wr_data=0, load_done=0, cpu_hold=1, error_code=0.
  - Internal: state=WAIT_SYNC, csum=0, word count=0, timeout counter=0.
  - Memory contents are not touched.
  - Reset mid-frame abandons the frame; words already written remain.
- States: WAIT_SYNC, GET_COUNT, GET_HI, GET_LO, GET_CSUM, FILL, DONE, ERROR.
- WAIT_SYNC:
  - boot_bypass=1 -> DONE (no writes).
  - Otherwise, rx_valid with rx_data==SYNC_BYTE -> GET_COUNT; all other bytes are ignored.
- GET_COUNT, on a byte N:
  - N==0 or N>DEPTH -> ERROR, code 3.
  - Otherwise latch N, set csum=N, set wr_addr=0, go to GET_HI.
- GET_HI, on a byte: latch hi, csum^=byte, go to GET_LO.
- GET_LO, on a byte:
  - Next cycle: wr_en=1, wr_data={hi,byte}, wr_addr=current index; csum^=byte.
  - Increment index. If the index reaches N -> GET_CSUM, else -> GET_HI.
  - Write latency: wr_en is registered 1 cycle after the lo-byte rx_valid.
- GET_CSUM, on a byte:
  - Byte==csum -> FILL if N<DEPTH, else DONE.
  - Mismatch -> ERROR, code 1.
- FILL:
  - Writes 16'h0000 to addresses N..DEPTH-1, one write per cycle, wr_en held high.
  - Then DONE. rx bytes are ignored.
- DONE: load_done=1, cpu_hold=0; rx bytes are ignored.
- ERROR: load_done=0; waits for load_start.
- Timeout:
  - The counter clears on every rx_valid and counts in GET_COUNT..GET_CSUM.
  - Reaching TIMEOUT_CYC-1 -> ERROR, code 2. The counter is idle in all other states.
- load_start, in any state except FILL (ignored in FILL):
  - Next state WAIT_SYNC; load_done=0, cpu_hold=1, error_code=0, csum and index cleared.
  - Takes priority over a simultaneous rx_valid, whose byte is discarded.
- wr_addr wraps only via the index limit; a write never occurs at or beyond DEPTH.
- wr_en is never asserted outside GET_LO-triggered writes and FILL.

Test Plan:
- Reset, then bytes A5 02 10 4E 30 44 28 -> writes: addr0=104E, addr1=3044; then 30 consecutive zero writes (addr2..31); load_done=1 on the cycle after the addr31 write; error_code=0.
- Same frame with checksum byte 29 -> two data writes, no FILL writes, error_code=1, load_done=0. Then load_start plus a correct frame -> load_done=1 and error_code=0.
- A5 03 12 34, then silence for TIMEOUT_CYC cycles -> error_code=2, exactly one write (addr0=1234), cpu_hold=1.
- A5 00 and A5 21 (with DEPTH=32) -> error_code=3, no writes.
- boot_bypass=1 after reset -> load_done=1 within 2 cycles, zero writes. Bytes A5.. sent afterward -> ignored.
- Frame with reset asserted between the hi and lo bytes of word 1 -> outputs return to reset values immediately, no write for word 1. A fresh full frame then loads correctly.
- load_start in the same cycle as an rx_valid carrying A5 -> the byte is discarded and the state is WAIT_SYNC; the next A5 starts the frame.
